pc_branch_unit: RTL

Program-counter and branch-resolution stage for the LFSR ISA core. It consumes the ALU `Zero` flag via a captured compare flag, resolves BNE through a writable branch-target lookup table, and drives the instruction-memory address. It also owns the Start/Ack program handshake with the testbench and keeps a saturating executed-instruction count.

---
 rtl/pc_branch_unit_pkg.sv | 15 +
 rtl/pc_branch_unit_branch_lut.sv | 36 +++
 rtl/pc_branch_unit.sv | 87 ++++++++
 3 files changed

// File: rtl/pc_branch_unit_pkg.sv
// Shared types and constants for the PC / branch-resolution stage.
package Definitions;
  typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} pc_state_t;

  localparam int DEF_PW = 10;
  localparam int DEF_LW = 4;
  localparam int DEF_CW = 16;
  localparam int LUT_INIT_N = 1 << DEF_LW;

  // Power-on branch targets: entry i points at i*16.
  localparam logic [DEF_PW-1:0] BRANCH_LUT_INIT [LUT_INIT_N] = '{
    10'h000, 10'h010, 10'h020, 10'h030, 10'h040, 10'h050, 10'h060, 10'h070,
    10'h080, 10'h090, 10'h0A0, 10'h0B0, 10'h0C0, 10'h0D0, 10'h0E0, 10'h0F0
  };
endpackage

// File: rtl/pc_branch_unit_branch_lut.sv
// Writable branch-target table: sync write, comb read, sync reload on Reset.
module branch_lut
  import Definitions::*;
#(
  parameter int PW = DEF_PW,
  parameter int LW = DEF_LW
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          WrEn,
  input  logic [LW-1:0] WrIdx,
  input  logic [PW-1:0] WrData,
  input  logic [LW-1:0] RdIdx,
  output logic [PW-1:0] RdData
);
  localparam int NE = 1 << LW;

  logic [PW-1:0] mem_q [NE];
  logic [PW-1:0] mem_d [NE];

  always_comb begin
    mem_d = mem_q;
    if (WrEn) mem_d[WrIdx] = WrData;
  end

  // Reads see registered contents, so a coincident write is not forwarded.
  assign RdData = mem_q[RdIdx];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NE; i++) mem_q[i] <= PW'(BRANCH_LUT_INIT[i % LUT_INIT_N]);
    end else begin
      mem_q <= mem_d;
    end
  end
endmodule

// File: rtl/pc_branch_unit.sv
// PC sequencing, BNE resolution, Start/Ack handshake and instruction count.
module pc_branch_unit
  import Definitions::*;
#(
  parameter int PW = DEF_PW,
  parameter int LW = DEF_LW,
  parameter int CW = DEF_CW
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Halt,
  input  logic          CmpEn,
  input  logic          BranchEn,
  input  logic          Zero,
  input  logic [LW-1:0] LutIdx,
  input  logic          LutWrEn,
  input  logic [LW-1:0] LutWrIdx,
  input  logic [PW-1:0] LutWrData,
  output logic [PW-1:0] PC,
  output logic          Running,
  output logic          Ack,
  output logic [CW-1:0] InstCnt
);
  pc_state_t     state_q, state_d;
  logic [PW-1:0] pc_q, pc_d;
  logic          flag_q, flag_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] lut_tgt;

  branch_lut #(.PW(PW), .LW(LW)) u_lut (
    .Clk    (Clk),
    .Reset  (Reset),
    .WrEn   (LutWrEn),
    .WrIdx  (LutWrIdx),
    .WrData (LutWrData),
    .RdIdx  (LutIdx),
    .RdData (lut_tgt)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flag_d  = flag_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE:  if (Start) state_d = ARMED;
      ARMED: if (!Start) state_d = RUN;
      RUN: begin
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        // Branch tests the flag as it stood before this cycle's CMP.
        if (Halt)                     state_d = DONE;
        else if (BranchEn && !flag_q) pc_d = lut_tgt;
        else                          pc_d = pc_q + 1'b1;
        if (CmpEn) flag_d = Zero;
      end
      DONE: begin
        if (Start) begin
          state_d = ARMED;
          pc_d    = '0;
          flag_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      flag_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flag_q  <= flag_d;
      cnt_q   <= cnt_d;
    end
  end

  assign PC      = pc_q;
  assign Running = (state_q == RUN);
  assign Ack     = (state_q == DONE);
  assign InstCnt = cnt_q;
endmodule
